// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI master controller and its shifter.
// Command word layout: [9:8] opcode, [7:0] payload.
package shared_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MODE = 3'd1,
    CMD  = 3'd2,
    GAP  = 3'd3,
    RX   = 3'd4,
    DONE = 3'd5
  } spi_mst_state_e;

  function automatic logic [1:0] opcode_of(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1:CMD_W-2];
  endfunction

endpackage

// File: rtl/spi_mst_shifter.sv
// Datapath for the SPI master: shared bit counter, command TX shift register
// and MISO RX shift register. Sequencing is decided by the controller FSM.
module spi_mst_shifter
  import shared_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CMD_W-1:0]  load_data,
  input  logic              tx_shift,
  input  logic              rx_shift,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  input  logic              miso,
  output logic              tx_bit,
  output logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] rx_next
);

  logic [CMD_W-1:0]  tx_sr;
  logic [DATA_W-1:0] rx_sr;

  // Zero fill means MOSI naturally idles low once all command bits are out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr <= '0;
    end else if (load) begin
      tx_sr <= load_data;
    end else if (tx_shift) begin
      tx_sr <= {tx_sr[CMD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr <= '0;
    end else if (rx_shift) begin
      rx_sr <= rx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rx_next = {rx_sr[DATA_W-2:0], miso};
  assign tx_bit  = tx_sr[CMD_W-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: sends a 10-bit command frame (preceded by a mode bit)
// and, for read-data commands, waits RD_GAP cycles then captures one MISO byte.
module spi_master_ctrl
  import shared_pkg::*;
#(
  parameter int RD_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RD_GAP - 1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(DATA_W - 1);

  spi_mst_state_e    state, next_state;
  logic [1:0]        op;
  logic              handshake;
  logic              tx_shift, rx_shift, cnt_clr, cnt_inc, rx_done;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rx_next;

  assign handshake = cmd_valid && cmd_ready;

  spi_mst_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (handshake),
    .load_data(cmd_data),
    .tx_shift (tx_shift),
    .rx_shift (rx_shift),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .miso     (MISO),
    .tx_bit   (MOSI),
    .cnt      (cnt),
    .rx_next  (rx_next)
  );

  // The counter restarts on every state change, so each phase counts from 0.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (handshake) next_state = MODE;
      MODE: next_state = CMD;
      CMD:  if (cnt == BIT_LAST) next_state = (op == OP_RD_DATA) ? GAP : DONE;
      GAP:  if (cnt == GAP_LAST) next_state = RX;
      RX:   if (cnt == RX_LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_shift = (state == CMD);
    rx_shift = (state == RX);
    cnt_clr  = (next_state != state);
    cnt_inc  = !cnt_clr && ((state == CMD) || (state == GAP) || (state == RX));
    rx_done  = (state == RX) && (next_state == DONE) && (op == OP_RD_DATA);
  end

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_WR_ADDR;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      SS_n      <= (next_state == IDLE) || (next_state == DONE);
      rsp_valid <= rx_done;
      if (handshake) op <= opcode_of(cmd_data);
      if (rx_done) rsp_data <= rx_next;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: one DUT with RD_GAP=2 and one with RD_GAP=1,
// each with its own MISO slave model; frames are captured per cycle and checked.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic [7:0] slave_byte = '0;
  bit         use_b = 1'b0;

  logic       cmd_ready_a, rsp_valid_a, busy_a, ss_n_a, mosi_a;
  logic       miso_a = 1'b0;
  logic [7:0] rsp_data_a;
  logic       cmd_ready_b, rsp_valid_b, busy_b, ss_n_b, mosi_b;
  logic       miso_b = 1'b0;
  logic [7:0] rsp_data_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready_a), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .busy(busy_a), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_master_ctrl #(.RD_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .busy(busy_b), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b)
  );

  logic       ss_s, mosi_s, rv_s;
  logic [7:0] rd_s;
  assign ss_s   = use_b ? ss_n_b      : ss_n_a;
  assign mosi_s = use_b ? mosi_b      : mosi_a;
  assign rv_s   = use_b ? rsp_valid_b : rsp_valid_a;
  assign rd_s   = use_b ? rsp_data_b  : rsp_data_a;

  // Slave models: frame cycle k counts from the first SS_n-low cycle; the RX
  // window starts at k = 11 + RD_GAP and the byte is presented MSB first.
  int k_a = 0;
  int k_b = 0;
  always @(negedge clk) begin
    if (ss_n_a) begin
      k_a = 0; miso_a = 1'b0;
    end else begin
      if (k_a >= 13 && k_a < 21) miso_a = slave_byte[3'(20 - k_a)];
      else miso_a = 1'b0;
      k_a++;
    end
  end
  always @(negedge clk) begin
    if (ss_n_b) begin
      k_b = 0; miso_b = 1'b0;
    end else begin
      if (k_b >= 12 && k_b < 20) miso_b = slave_byte[3'(19 - k_b)];
      else miso_b = 1'b0;
      k_b++;
    end
  end

  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] sbyte, input bit b,
                           output int low, output logic [31:0] bits,
                           output int rsp_cnt, output logic [7:0] rsp_last);
    use_b = b;
    slave_byte = sbyte;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = cmd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = ~cmd;
    low = 0; bits = '0; rsp_cnt = 0; rsp_last = '0;
    for (int i = 0; i < 28; i++) begin
      if (!ss_s) begin bits = {bits[30:0], mosi_s}; low++; end
      if (rv_s) begin rsp_cnt++; rsp_last = rd_s; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; use_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ss_n_a, mosi_a, cmd_ready_a, rsp_valid_a, busy_a} !== 5'b10000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got ss/mosi/rdy/rv/busy=%b expected 10000",
               {ss_n_a, mosi_a, cmd_ready_a, rsp_valid_a, busy_a});
    end
    checks++;
    if (rsp_data_a !== 8'h00) begin
      fails++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", rsp_data_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got rdy=%b busy=%b expected rdy=1 busy=0",
               cmd_ready_a, busy_a);
    end
  endtask

  task automatic test_write_addr();
    int low, rc; logic [31:0] bits; logic [7:0] rl;
    run_frame(10'h0A5, 8'h00, 1'b0, low, bits, rc, rl);
    checks++;
    if (low !== 11) begin fails++; $display("[TB] FAIL wr_len: got %0d expected 11", low); end
    checks++;
    if (bits[10:0] !== 11'b00010100101) begin
      fails++; $display("[TB] FAIL wr_mosi: got %b expected 00010100101", bits[10:0]);
    end
    checks++;
    if (rc !== 0) begin fails++; $display("[TB] FAIL wr_no_rsp: got %0d pulses expected 0", rc); end
    checks++;
    if (ss_n_a !== 1'b1 || cmd_ready_a !== 1'b1) begin
      fails++; $display("[TB] FAIL wr_idle_after: got ss=%b rdy=%b expected 1 1", ss_n_a, cmd_ready_a);
    end
  endtask

  task automatic test_read_data();
    int low, rc; logic [31:0] bits; logic [7:0] rl;
    run_frame(10'h300, 8'hC3, 1'b0, low, bits, rc, rl);
    checks++;
    if (low !== 21) begin fails++; $display("[TB] FAIL rd_len: got %0d expected 21", low); end
    checks++;
    if (bits[20:0] !== 21'b111000000000000000000) begin
      fails++; $display("[TB] FAIL rd_mosi: got %b expected 111 then 18 zeros", bits[20:0]);
    end
    checks++;
    if (rc !== 1 || rl !== 8'hC3) begin
      fails++; $display("[TB] FAIL rd_rsp: got %0d pulses data %h expected 1 pulse data c3", rc, rl);
    end
    run_frame(10'h1A5, 8'h5A, 1'b0, low, bits, rc, rl);
    checks++;
    if (rc !== 0 || rsp_data_a !== 8'hC3) begin
      fails++; $display("[TB] FAIL rd_hold: got %0d pulses data %h expected 0 pulses data c3", rc, rsp_data_a);
    end
  endtask

  task automatic test_back_to_back();
    logic ss_log [40];
    logic mosi_log [40];
    int idx, len1, hi, len2, extra;
    logic [10:0] b1, b2;
    use_b = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 10'h1FF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ss_log[i] = ss_n_a; mosi_log[i] = mosi_a;
      if (i == 0) cmd_data = 10'h200;
      if (i > 0 && !ss_log[i] && ss_log[i-1]) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    idx = 0; len1 = 0; hi = 0; len2 = 0; extra = 0; b1 = '0; b2 = '0;
    while (idx < 40 && !ss_log[idx]) begin b1 = {b1[9:0], mosi_log[idx]}; len1++; idx++; end
    while (idx < 40 && ss_log[idx]) begin hi++; idx++; end
    while (idx < 40 && !ss_log[idx]) begin b2 = {b2[9:0], mosi_log[idx]}; len2++; idx++; end
    while (idx < 40) begin if (!ss_log[idx]) extra++; idx++; end
    checks++;
    if (len1 !== 11 || b1 !== 11'b00111111111) begin
      fails++; $display("[TB] FAIL b2b_frame1: got len %0d mosi %b expected 11 00111111111", len1, b1);
    end
    checks++;
    if (hi !== 2) begin fails++; $display("[TB] FAIL b2b_gap: got %0d high cycles expected 2", hi); end
    checks++;
    if (len2 !== 11 || b2 !== 11'b11000000000) begin
      fails++; $display("[TB] FAIL b2b_frame2: got len %0d mosi %b expected 11 11000000000", len2, b2);
    end
    checks++;
    if (extra !== 0) begin fails++; $display("[TB] FAIL b2b_extra: got %0d extra low cycles expected 0", extra); end
  endtask

  task automatic test_handshake();
    int falls, bad, lows;
    logic prev;
    use_b = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 10'h0A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    falls = 0; bad = 0; lows = 0; prev = ss_n_a;
    for (int i = 0; i < 30; i++) begin
      if (!ss_n_a) lows++;
      if ((!ss_n_a || busy_a) && cmd_ready_a) bad++;
      if (i == 11 && (cmd_ready_a !== 1'b0 || busy_a !== 1'b1)) bad++;
      if (prev && !ss_n_a) falls++;
      prev = ss_n_a;
      if (i == 3) begin cmd_valid = 1'b1; cmd_data = 10'h2AA; end
      if (i == 12) cmd_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin fails++; $display("[TB] FAIL hs_ready_low: got %0d bad cycles expected 0", bad); end
    checks++;
    if (falls !== 0 || lows !== 11) begin
      fails++; $display("[TB] FAIL hs_ignored: got %0d new frames %0d low cycles expected 0 and 11", falls, lows);
    end
  endtask

  task automatic test_reset_mid_frame();
    int low, rc, rv_seen; logic [31:0] bits; logic [7:0] rl;
    use_b = 1'b0; slave_byte = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 10'h3AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ss_n_a, mosi_a, cmd_ready_a, rsp_valid_a, busy_a} !== 5'b10000 || rsp_data_a !== 8'h00) begin
      fails++;
      $display("[TB] FAIL rst_mid_outputs: got ss/mosi/rdy/rv/busy=%b data %h expected 10000 00",
               {ss_n_a, mosi_a, cmd_ready_a, rsp_valid_a, busy_a}, rsp_data_a);
    end
    rv_seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid_a) rv_seen++; end
    rst_n = 1'b1;
    repeat (25) begin @(negedge clk); if (rsp_valid_a || !ss_n_a) rv_seen++; end
    checks++;
    if (rv_seen !== 0) begin fails++; $display("[TB] FAIL rst_mid_abandon: got %0d resumed cycles expected 0", rv_seen); end
    run_frame(10'h0A5, 8'h00, 1'b0, low, bits, rc, rl);
    checks++;
    if (low !== 11 || bits[10:0] !== 11'b00010100101 || rc !== 0) begin
      fails++; $display("[TB] FAIL rst_mid_next: got len %0d mosi %b rsp %0d expected 11 00010100101 0",
                        low, bits[10:0], rc);
    end
  endtask

  task automatic test_gap1();
    int low, rc; logic [31:0] bits; logic [7:0] rl;
    run_frame(10'h3FF, 8'h81, 1'b1, low, bits, rc, rl);
    checks++;
    if (low !== 20 || bits[19:0] !== 20'b11111111111000000000) begin
      fails++; $display("[TB] FAIL gap1_frame: got len %0d mosi %b expected 20 11111111111000000000",
                        low, bits[19:0]);
    end
    checks++;
    if (rc !== 1 || rl !== 8'h81) begin
      fails++; $display("[TB] FAIL gap1_rsp: got %0d pulses data %h expected 1 pulse data 81", rc, rl);
    end
    use_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_handshake();
    test_reset_mid_frame();
    test_gap1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter RD_GAP, default 2: idle MOSI cycles between the last command bit and the first MISO capture in a read-data frame; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_data  in  10  command word; [9:8] = opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] = payload.
REQ-006 cmd_ready  out  1  high only when the block can accept a command.
REQ-007 rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
REQ-008 rsp_data  out  8  byte captured from MISO in a read-data frame.
REQ-009 busy  out  1  high whenever state != IDLE.
REQ-010 SS_n  out  1  slave select, active-low, registered.
REQ-011 MOSI  out  1  serial data to the slave, registered.
REQ-012 MISO  in  1  serial data from the slave.

Function
REQ-013 FSM states: IDLE, MODE, CMD, GAP, RX, DONE; all outputs come straight from registers.
REQ-014 IDLE: cmd_ready=1, SS_n=1, MOSI=0; a handshake (cmd_valid&&cmd_ready at posedge) latches cmd_data and moves to MODE; cmd_valid with cmd_ready=0 is ignored, not queued.
REQ-015 MODE, 1 cycle: SS_n=0, MOSI=cmd[9] (read/write selector bit).
REQ-016 CMD, 10 cycles: SS_n=0, MOSI=cmd[9] down to cmd[0], MSB first, one bit per cycle; a 4-bit counter tracks the bits.
REQ-017 After the 10th CMD bit, opcode 11 goes to GAP; every other opcode goes to DONE.
REQ-018 GAP, RD_GAP cycles: SS_n=0, MOSI=0.
REQ-019 RX, 8 cycles: SS_n=0, MOSI=0; MISO is sampled at each posedge and shifted in MSB first.
REQ-020 DONE, 1 cycle: SS_n=1, cmd_ready=0; if the frame was opcode 11, rsp_valid=1 and rsp_data holds the captured byte; then go to IDLE.
REQ-021 Frame length (SS_n low): 11 cycles for opcodes 00/01/10; 19+RD_GAP cycles for opcode 11.
REQ-022 SS_n is high for at least 2 cycles (DONE + IDLE) between frames, including back-to-back commands; cmd_valid held high gives one new frame every 13 cycles (opcodes 00/01/10).
REQ-023 rsp_data holds its value until the next read-data DONE; rsp_valid never asserts for opcodes 00/01/10.
REQ-024 A latched command is not affected by changes on cmd_data mid-frame.

Reset
REQ-025 rst_n low, at any time including mid-frame: state=IDLE, SS_n=1, MOSI=0, cmd_ready=0 while asserted, rsp_valid=0, rsp_data=8'h00, busy=0, counters and shift register cleared.
REQ-026 An interrupted frame is abandoned: no rsp_valid, no resume; cmd_ready=1 on the first posedge after deassertion.

Structure
REQ-027 shared_pkg holds: the state enum spi_mst_state_e, CMD_W=10, DATA_W=8, and the opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA.
REQ-028 One sub-module, spi_mst_shifter (bit counter, TX shift register, RX shift register), is instantiated once; the FSM stays in spi_master_ctrl.

Verification
REQ-029 Reset mid-frame: rst_n low during CMD bit 5 -> SS_n=1 immediately, no rsp_valid, next command produces a clean 11-cycle frame.
REQ-030 Write-addr: cmd_data=10'h0A5 -> SS_n low 11 cycles, MOSI = 0,0,0,1,0,1,0,0,1,0,1, then SS_n=1, rsp_valid never asserts.
REQ-031 Read-data: cmd_data=10'h300, slave model drives MISO=8'hC3 in RX -> MOSI = 1,1,1,0,0,0,0,0,0,0,0, then 2 GAP cycles, rsp_valid pulse with rsp_data=8'hC3; SS_n low 21 cycles.
REQ-032 Back-to-back: cmd_valid held high with 10'h1FF then 10'h200 -> two frames, SS_n high exactly 2 cycles between them, second frame MOSI starts with 1.
REQ-033 Handshake: cmd_valid pulsed while busy=1 -> ignored, cmd_ready=0 throughout, no extra frame.
REQ-034 RD_GAP=1 build, read 10'h3FF, MISO=8'h81 -> SS_n low 20 cycles, rsp_data=8'h81.
